// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response channel plus the IF/ID presentation bundle.
// Latency: none, wires only.
// Backpressure: imem_req_ready throttles requests; the IF/ID consumer holds via the fetch_unit stall input.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_inst;

   modport master (
      output imem_req_valid, imem_addr, if_id_valid, if_id_pc, if_id_inst,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_addr, if_id_valid, if_id_pc, if_id_inst,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem request issue with bounded in-flight fetches, in-order buffer to IF/ID.
// Latency: 1 cycle from imem_rsp_valid to if_id_valid when the buffer is empty.
// Backpressure: stall holds the IF/ID head; requests stop once in-flight + buffered reaches MAX_OUTSTANDING.
// Option: FETCH_MISALIGN_CHECK_EN adds fetch_misalign and blocks fetch after a misaligned redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  npc_in,
   input  logic         redirect,
   input  logic         stall,
   output logic [31:0]  pc_out,
   fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic         fetch_misalign
`endif
);
   localparam int         DEPTH   = MAX_OUTSTANDING;
   localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

   // Depth is at most 2, so single-bit pointers suffice.
   function automatic logic ptr_inc(input logic p);
      return (DEPTH == 1) ? 1'b0 : ~p;
   endfunction

   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_q, out_d;          // accepted requests not yet returned (killed ones included)
   logic [1:0]  buf_cnt_q, buf_cnt_d;
   logic [1:0]  kill_q, kill_d;
   logic        pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;
   logic        buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
   logic [31:0] pcf_q [DEPTH];
   logic [31:0] pcf_d [DEPTH];
   logic [31:0] buf_pc_q [DEPTH];
   logic [31:0] buf_pc_d [DEPTH];
   logic [31:0] buf_inst_q [DEPTH];
   logic [31:0] buf_inst_d [DEPTH];

   logic        blocked;
   logic [31:0] redirect_pc;
   logic        req_vld, req_acc, rsp_kill, rsp_keep, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign blocked        = misalign_q;
   assign redirect_pc    = npc_in;
   assign fetch_misalign = misalign_q;

   // Flag follows the alignment of the most recent redirect target.
   always_comb begin
      misalign_d = misalign_q;
      if (redirect) misalign_d = (npc_in[1:0] != 2'b00);
   end

   // Misalignment flag register.
   always_ff @(posedge clk) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`else
   assign blocked     = 1'b0;
   assign redirect_pc = {npc_in[31:2], 2'b00};
`endif

   // Request is held off during reset so the first one appears as soon as rst_n rises.
   assign req_vld  = rst_n && !redirect && !blocked &&
                     (({1'b0, out_q} + {1'b0, buf_cnt_q}) < MAX_CNT);
   assign req_acc  = req_vld && bus.imem_req_ready;
   assign rsp_kill = bus.imem_rsp_valid && (kill_q != 2'd0);
   assign rsp_keep = bus.imem_rsp_valid && (kill_q == 2'd0);
   assign pop      = (buf_cnt_q != 2'd0) && !stall;

   // Next-state: PC advance, PC FIFO, response buffer, kill accounting; redirect overrides last.
   always_comb begin
      pc_d       = pc_q;
      out_d      = out_q;
      buf_cnt_d  = buf_cnt_q;
      kill_d     = kill_q;
      pcf_wr_d   = pcf_wr_q;
      pcf_rd_d   = pcf_rd_q;
      buf_wr_d   = buf_wr_q;
      buf_rd_d   = buf_rd_q;
      pcf_d      = pcf_q;
      buf_pc_d   = buf_pc_q;
      buf_inst_d = buf_inst_q;

      if (req_acc) begin
         pc_d            = pc_q + 32'd4;
         pcf_d[pcf_wr_q] = pc_q;
         pcf_wr_d        = ptr_inc(pcf_wr_q);
         out_d           = out_q + 2'd1;
      end
      if (bus.imem_rsp_valid) out_d = out_d - 2'd1;
      if (rsp_kill) kill_d = kill_q - 2'd1;
      if (rsp_keep) begin
         buf_pc_d[buf_wr_q]   = pcf_q[pcf_rd_q];
         buf_inst_d[buf_wr_q] = bus.imem_rsp_data;
         buf_wr_d             = ptr_inc(buf_wr_q);
         pcf_rd_d             = ptr_inc(pcf_rd_q);
         buf_cnt_d            = buf_cnt_q + 2'd1;
      end
      if (pop) begin
         buf_rd_d  = ptr_inc(buf_rd_q);
         buf_cnt_d = buf_cnt_d - 2'd1;
      end
      if (redirect) begin
         // No request is accepted this cycle, so out_d is exactly the requests still to come back;
         // a response arriving now is already excluded and counts as returned.
         pc_d      = redirect_pc;
         buf_cnt_d = 2'd0;
         pcf_wr_d  = 1'b0;
         pcf_rd_d  = 1'b0;
         buf_wr_d  = 1'b0;
         buf_rd_d  = 1'b0;
         kill_d    = out_d;
      end
   end

   // State registers; storage is cleared so IF/ID reads zero after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         out_q     <= 2'd0;
         buf_cnt_q <= 2'd0;
         kill_q    <= 2'd0;
         pcf_wr_q  <= 1'b0;
         pcf_rd_q  <= 1'b0;
         buf_wr_q  <= 1'b0;
         buf_rd_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pcf_q[i]      <= 32'd0;
            buf_pc_q[i]   <= 32'd0;
            buf_inst_q[i] <= 32'd0;
         end
      end else begin
         pc_q       <= pc_d;
         out_q      <= out_d;
         buf_cnt_q  <= buf_cnt_d;
         kill_q     <= kill_d;
         pcf_wr_q   <= pcf_wr_d;
         pcf_rd_q   <= pcf_rd_d;
         buf_wr_q   <= buf_wr_d;
         buf_rd_q   <= buf_rd_d;
         pcf_q      <= pcf_d;
         buf_pc_q   <= buf_pc_d;
         buf_inst_q <= buf_inst_d;
      end
   end

   assign pc_out             = pc_q;
   assign bus.imem_req_valid = req_vld;
   assign bus.imem_addr      = pc_q;
   assign bus.if_id_valid    = (buf_cnt_q != 2'd0);
   assign bus.if_id_pc       = buf_pc_q[buf_rd_q];
   assign bus.if_id_inst     = buf_inst_q[buf_rd_q];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/stall/redirect stimulus against a sequential-stream reference model.
// Latency: memory answers in order, at least one cycle after acceptance.
// Backpressure: random imem_req_ready and random stall.
module tb_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          MAXO   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] npc_in = 32'd0;
   logic        redirect = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misalign;
   bit          mis_model = 1'b0;
`endif

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(MAXO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .npc_in   (npc_in),
      .redirect (redirect),
      .stall    (stall),
      .pc_out   (pc_out),
      .bus      (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int pops = 0;
   int cyc = 0;

   logic [31:0] exp_q [$];     // PCs the IF/ID stage must present, in order
   logic [31:0] exp_addr;      // next address the memory must see
   logic [31:0] mq_addr [$];   // memory model: accepted, not yet answered
   int          mq_due [$];

   int rdy_pct = 100, lat_fix = 0, lat_rnd = 0, stall_pct = 0, redir_pct = 0;
   bit force_redir = 1'b0;
   logic [31:0] force_tgt = 32'd0;
   bit mon_en = 1'b0;

   bit          pv = 1'b0;
   logic [31:0] ppc, pinst;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D ^ a;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_stream(input logic [31:0] tgt);
      exp_q.delete();
      for (int i = 0; i < 300; i++) exp_q.push_back(tgt + 32'(4 * i));
      exp_addr = tgt;
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(7) == 0) t[31:8] = 24'hFFFF_FF;
      if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3));
      else                        t[1:0] = 2'b00;
      return t;
   endfunction

   // One clock of stimulus: inputs at negedge, memory acceptance at +1, model update at +3.
   task automatic drive_cycle();
      @(negedge clk);
      cyc++;
      stall    = ($urandom_range(99) < stall_pct);
      redirect = 1'b0;
      if (force_redir) begin
         redirect    = 1'b1;
         npc_in      = force_tgt;
         force_redir = 1'b0;
      end else if ($urandom_range(99) < redir_pct) begin
         redirect = 1'b1;
         npc_in   = pick_target();
      end
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = inst_of(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
      #1;
      if (redirect) check("req_blocked_by_redirect", 32'(bus.imem_req_valid), 32'd0);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
         check("imem_addr", bus.imem_addr, exp_addr);
`ifdef FETCH_MISALIGN_CHECK_EN
         check("req_while_misaligned", 32'(mis_model), 32'd0);
`endif
         exp_addr = exp_addr + 32'd4;
         mq_addr.push_back(bus.imem_addr);
         mq_due.push_back(cyc + 1 + lat_fix + $urandom_range(lat_rnd));
         total++;
         if (mq_addr.size() > MAXO) begin
            bad++;
            $display("FAIL in_flight: got %0d allowed %0d (cycle %0d)", mq_addr.size(), MAXO, cyc);
         end
      end
      #2;
      if (redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
         if (npc_in[1:0] != 2'b00) begin
            mis_model = 1'b1;
            exp_q.delete();
         end else begin
            mis_model = 1'b0;
            push_stream(npc_in);
         end
`else
         push_stream({npc_in[31:2], 2'b00});
`endif
      end
   endtask

   // Reset (possibly mid-operation), check cleared outputs, release and check the first request.
   task automatic do_reset();
      @(negedge clk);
      mon_en = 1'b0;
      rst_n = 1'b0;
      redirect = 1'b0;
      stall = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 32'd0;
      mq_addr.delete();
      mq_due.delete();
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_if_id_valid", 32'(bus.if_id_valid), 32'd0);
      check("rst_if_id_pc", bus.if_id_pc, 32'd0);
      check("rst_if_id_inst", bus.if_id_inst, 32'd0);
      check("rst_pc_out", pc_out, RST_PC);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misalign", 32'(fetch_misalign), 32'd0);
      mis_model = 1'b0;
`endif
      push_stream(RST_PC);
      rst_n = 1'b1;
      #1;
      check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("first_req_addr", bus.imem_addr, RST_PC);
      #2;
      mon_en = 1'b1;
   endtask

   task automatic set_knobs(input int r, input int lf, input int lr, input int s, input int d);
      rdy_pct = r; lat_fix = lf; lat_rnd = lr; stall_pct = s; redir_pct = d;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      force_tgt = t;
      force_redir = 1'b1;
   endtask

   // Monitor: pops the expected stream on every IF/ID consume and checks hold during stall.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!mon_en) begin
            pv = 1'b0;
         end else begin
            if (pv) begin
               check("stall_hold_valid", 32'(bus.if_id_valid), 32'd1);
               check("stall_hold_pc", bus.if_id_pc, ppc);
               check("stall_hold_inst", bus.if_id_inst, pinst);
            end
            pv    = bus.if_id_valid && stall && !redirect;
            ppc   = bus.if_id_pc;
            pinst = bus.if_id_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
            check("fetch_misalign", 32'(fetch_misalign), 32'(mis_model));
`endif
            if (bus.if_id_valid && !stall) begin
               pops++;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_if_id: got pc %h with nothing expected (cycle %0d)", bus.if_id_pc, cyc);
               end else begin
                  logic [31:0] e;
                  e = exp_q.pop_front();
                  check("if_id_pc", bus.if_id_pc, e);
                  check("if_id_inst", bus.if_id_inst, inst_of(e));
               end
            end
         end
      end
   end

   initial begin
      int p0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      exp_addr = RST_PC;
      do_reset();

      // Plain streaming, single-cycle memory.
      set_knobs(100, 0, 0, 0, 0);
      p0 = pops;
      repeat (30) drive_cycle();
      check("stream_progress", 32'(pops - p0 >= 15), 32'd1);

      // Three-cycle stall in the middle of streaming.
      set_knobs(100, 0, 0, 100, 0);
      repeat (3) drive_cycle();
      set_knobs(100, 0, 0, 0, 0);
      repeat (10) drive_cycle();

      // Long latency so two requests are in flight when the redirect lands.
      set_knobs(100, 3, 0, 0, 0);
      repeat (8) drive_cycle();
      redirect_to(32'h0000_0100);
      repeat (25) drive_cycle();

      // Short latency: redirects now tend to coincide with a response.
      set_knobs(100, 1, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         repeat (3 + k) drive_cycle();
         redirect_to(32'h0000_0200 + 32'(k * 32'h40));
         repeat (6) drive_cycle();
      end

      // Address wrap at the top of the address space.
      set_knobs(100, 0, 0, 0, 0);
      redirect_to(32'hFFFF_FFF8);
      repeat (15) drive_cycle();

      // Misaligned redirect target.
      redirect_to(32'h0000_0102);
      repeat (10) drive_cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_to(32'h0000_0104);
      repeat (10) drive_cycle();
`endif

      // Randomized stretches.
      for (int k = 0; k < 40; k++) begin
         set_knobs($urandom_range(30, 100), $urandom_range(0, 2), $urandom_range(0, 3),
                   $urandom_range(0, 60), $urandom_range(0, 15));
         repeat (60) drive_cycle();
      end

      // Drain from a clean aligned redirect and confirm forward progress.
      set_knobs(100, 0, 0, 0, 0);
      redirect_to(32'h0000_4000);
      p0 = pops;
      repeat (60) drive_cycle();
      check("drain_progress", 32'(pops - p0 >= 25), 32'd1);

      // Reset mid-operation with requests in flight.
      set_knobs(100, 2, 0, 0, 0);
      repeat (5) drive_cycle();
      do_reset();
      set_knobs(100, 0, 0, 0, 0);
      p0 = pops;
      repeat (30) drive_cycle();
      check("post_reset_progress", 32'(pops - p0 >= 12), 32'd1);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of in-flight plus buffered fetches (legal values 1..2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset, which is synchronous and active-low.
REQ-005 SHALL have port npc_in, input, 32, the redirect target from the npc block.
REQ-006 SHALL have port redirect, input, 1, taken branch or jump; load npc_in and kill younger fetches.
REQ-007 SHALL have port pc_out, output, 32, the current fetch PC; this drives the npc block pc input.
REQ-008 SHALL have port imem_req_valid, output, 1, the fetch request.
REQ-009 SHALL have port imem_req_ready, input, 1, memory accepts the request.
REQ-010 SHALL have port imem_addr, output, 32, the request address, equal to pc_out.
REQ-011 SHALL have port imem_rsp_valid, input, 1, an instruction return, in order, at least 1 cycle after acceptance.
REQ-012 SHALL have port imem_rsp_data, input, 32, the returned instruction.
REQ-013 SHALL have port stall, input, 1, hazard unit hold of IF/ID.
REQ-014 SHALL have port if_id_valid, output, 1, marking if_id_pc and if_id_inst as valid.
REQ-015 SHALL have port if_id_pc, output, 32, the PC of the presented instruction.
REQ-016 SHALL have port if_id_inst, output, 32, the presented instruction.

Function
REQ-017 SHALL advance pc by +4 (mod 2^32, wrapping 32'hFFFF_FFFC to 0) on each accepted request (imem_req_valid && imem_req_ready).
REQ-018 SHALL set imem_req_valid = !redirect && (outstanding + buffered) < MAX_OUTSTANDING, independent of stall except through occupancy.
REQ-019 SHALL record the PC of each accepted request in an in-order PC FIFO of depth MAX_OUTSTANDING.
REQ-020 SHALL write each non-killed response (data plus recorded PC) into a response buffer of depth MAX_OUTSTANDING; it SHALL never overflow by construction.
REQ-021 SHALL drive if_id_* from the buffer head, with if_id_valid = buffer non-empty, and pop the head in a cycle where if_id_valid && !stall.
REQ-022 SHALL hold if_id_pc and if_id_inst stable while stall=1, and hold them stable or replace them only on a pop.
REQ-023 On redirect, SHALL load pc <= npc_in next cycle, empty the buffer and PC FIFO, and set kill_cnt to the number of outstanding, not-yet-returned requests.
REQ-024 SHALL discard the next kill_cnt responses (decrementing kill_cnt each time) and not present them.
REQ-025 SHALL count a response arriving in the same cycle as redirect as returned, not killed.
REQ-026 SHALL apply redirect and pop in the same cycle with the result that the buffer is empty.
REQ-027 SHALL apply push and pop in the same cycle with occupancy unchanged.
REQ-028 SHALL keep accepting responses while stall=1.
REQ-029 SHALL have a fetch latency of 1 cycle from imem_rsp_valid to if_id_valid when the buffer is empty.

Reset
REQ-030 While rst_n=0 at a clock edge, SHALL set pc=RESET_PC, clear outstanding, buffer, PC FIFO and kill_cnt, and drive imem_req_valid=0, if_id_valid=0, if_id_pc=0, if_id_inst=0.
REQ-031 SHALL treat a reset applied mid-operation as an abandonment of all in-flight requests; the memory side is reset together with this block.
REQ-032 SHALL issue the first request at address RESET_PC in the first cycle after rst_n rises.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHECK_EN SHALL control the misalignment check.
REQ-034 With FETCH_MISALIGN_CHECK_EN defined, SHALL add output fetch_misalign (1 bit, reset 0), set it when redirect occurs with npc_in[1:0]!=0, and hold imem_req_valid=0 while it is set.
REQ-035 With FETCH_MISALIGN_CHECK_EN defined, SHALL clear fetch_misalign on the next redirect with an aligned target.
REQ-036 Without FETCH_MISALIGN_CHECK_EN, SHALL not have the fetch_misalign port and SHALL load pc with {npc_in[31:2],2'b00}.

Verification
REQ-037 Reset release, imem ready=1 and 1-cycle response, stall=0 -> imem_addr 0x0,0x4,0x8...; if_id_pc follows the same sequence one cycle after each response.
REQ-038 Streaming, then stall=1 for 3 cycles -> at most 2 requests beyond the held instruction; if_id_* frozen; no instruction lost or duplicated after release.
REQ-039 Two requests outstanding (0x8,0xC), redirect with npc_in=0x100 -> both responses dropped; next if_id_pc=0x100 then 0x104.
REQ-040 Redirect in the same cycle as the response for 0x8 -> 0x8 is not presented, the still-outstanding 0xC response is dropped, and only the 0x200 stream follows.
REQ-041 RESET_PC=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-042 With FETCH_MISALIGN_CHECK_EN, redirect with npc_in=0x102 -> fetch_misalign=1 and no requests; a later redirect to 0x104 -> flag clears and fetch resumes at 0x104. Without the macro, a redirect to 0x102 fetches 0x100.
